dcache_mem_arbiter: RTL and testbench
=====================================

# dcache_mem_arbiter

Sits directly downstream of the data cache, between its per-consumer controller-side miss/write-back interface and the global memory. Accepts up to NUM_CONSUMERS outstanding read or write requests and multiplexes them onto NUM_CHANNELS memory channels with round-robin fairness. Relays memory responses back to the requesting consumer slot with a valid/ready handshake.

## Interface
- ADDR_BITS, 8, address width
- DATA_BITS, 8, memory word width
- NUM_CONSUMERS, 8, request slots from the dcache (one per LSU)
- NUM_CHANNELS, 4, concurrent memory channels; must be ≥1
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_read_valid  in  NUM_CONSUMERS  read request per slot
- req_read_address  in  ADDR_BITS×NUM_CONSUMERS  read address
- req_read_ready  out  NUM_CONSUMERS  read data valid / request done
- req_read_data  out  DATA_BITS×NUM_CONSUMERS  returned read data
- req_write_valid  in  NUM_CONSUMERS  write (write-back) request per slot
- req_write_address  in  ADDR_BITS×NUM_CONSUMERS  write address
- req_write_data  in  DATA_BITS×NUM_CONSUMERS  write data
- req_write_ready  out  NUM_CONSUMERS  write accepted by memory
- mem_read_valid  out  NUM_CHANNELS  read request to memory
- mem_read_address  out  ADDR_BITS×NUM_CHANNELS
- mem_read_ready  in  NUM_CHANNELS  memory read complete
- mem_read_data  in  DATA_BITS×NUM_CHANNELS
- mem_write_valid  out  NUM_CHANNELS
- mem_write_address  out  ADDR_BITS×NUM_CHANNELS
- mem_write_data  out  DATA_BITS×NUM_CHANNELS
- mem_write_ready  in  NUM_CHANNELS  memory write complete

## Operation
- Per-channel FSM: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY. Per-channel register holds the owning slot index.
- claimed[NUM_CONSUMERS]: set while a slot is owned by any channel. A claimed slot is never granted to a second channel.
- IDLE: scan slots starting at rr_ptr, modulo NUM_CONSUMERS. Select the first slot that is unclaimed and has read_valid or write_valid set.
  - If write_valid is set, issue a write: mem_write_valid=1, latch address and data, go to WRITE_WAIT.
  - Otherwise issue a read: mem_read_valid=1, latch address, go to READ_WAIT.
  - Write takes priority when both valids are set on one slot.
- Same-cycle grants: channels are served in ascending index order. Each channel excludes slots granted to lower channels in that cycle.
- rr_ptr update: becomes (last slot granted this cycle)+1 mod NUM_CONSUMERS. Unchanged if no grant.
- READ_WAIT, on mem_read_ready:
  - Clear mem_read_valid.
  - If the slot's read_valid is still high: latch mem_read_data into req_read_data[slot], set req_read_ready[slot], go to READ_RELAY.
  - Otherwise discard the data, clear the claim, go to IDLE.
- WRITE_WAIT, on mem_write_ready: same as READ_WAIT using the write signals and req_write_ready. No data is returned.
- RELAY: hold ready high until the slot's corresponding valid is low. Then clear ready and the claim, and go to IDLE.
- Addresses and data pass through unmodified. No arithmetic beyond the pointer wrap.

## Timing
- Reset (reset=0, asynchronous): every output is 0 (all valid, ready, address and data buses). All FSMs go to IDLE, rr_ptr=0, claimed=0.
- Reset mid-transaction abandons the memory request. The memory side must tolerate valid dropping.
- All outputs are registered.
  - Request valid sampled high at edge N → mem_*_valid high after edge N.
  - mem_*_ready sampled at edge K → req ready and data after edge K, mem valid low after edge K.
- Minimum round trip with mem ready one cycle after mem valid: 3 cycles from request valid to req ready.
- Consumer drops valid at edge R while in RELAY → ready low and channel IDLE after edge R.
  - The channel may regrant at edge R+1.
  - The same slot is eligible again from edge R+1.
- More pending slots than channels: the excess waits. With all requesters pending, no slot waits longer than ceil(NUM_CONSUMERS/NUM_CHANNELS) grant rounds.
- mem ready is ignored while the channel is IDLE or in RELAY.

## Test plan
- Single read: slot 3 reads 0x42, memory returns 0xA5 one cycle after mem valid.
  - Expect channel 0 mem_read_address=0x42.
  - Expect req_read_ready[3] with data 0xA5, 3 cycles after request.
  - Ready drops the cycle after valid drops.
- Write priority: slot 1 asserts write 0x10/0x77 and read 0x20 together.
  - Expect a mem write of 0x10/0x77 first and req_write_ready[1].
  - The read is issued only after the write handshake completes.
- Oversubscription: all 8 slots read at once with 4 channels.
  - Expect slots 0–3 granted to channels 0–3, rr_ptr=4.
  - Slots 4–7 are granted as channels free; every slot is served exactly once.
- Abandon: slot 5 drops read_valid during READ_WAIT.
  - On mem_read_ready, req_read_ready[5] stays 0 and the channel returns to IDLE.
- Async reset: reset asserted mid-READ_WAIT, between clock edges.
  - Expect all outputs 0 immediately and rr_ptr=0.
  - After release, a new request is granted to channel 0.

Source files
------------

// File: rtl/dcache_mem_arbiter.sv
// Data-cache to memory arbiter: multiplexes per-slot read/write-back requests
// onto NUM_CHANNELS memory channels with round-robin slot selection.
module dcache_mem_arbiter #(
   parameter int unsigned ADDR_BITS     = 8,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned NUM_CONSUMERS = 8,
   parameter int unsigned NUM_CHANNELS  = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           req_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] req_read_address,
   output logic [NUM_CONSUMERS-1:0]           req_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] req_read_data,
   input  logic [NUM_CONSUMERS-1:0]           req_write_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] req_write_address,
   input  logic [NUM_CONSUMERS*DATA_BITS-1:0] req_write_data,
   output logic [NUM_CONSUMERS-1:0]           req_write_ready,
   output logic [NUM_CHANNELS-1:0]            mem_read_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
   input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
   output logic [NUM_CHANNELS-1:0]            mem_write_valid,
   output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
   output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
   input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

   localparam int unsigned SLOT_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ_WAIT,
      S_WRITE_WAIT,
      S_READ_RELAY,
      S_WRITE_RELAY
   } state_e;

   state_e                             state_q [NUM_CHANNELS];
   state_e                             state_d [NUM_CHANNELS];
   logic [SLOT_W-1:0]                  owner_q [NUM_CHANNELS];
   logic [SLOT_W-1:0]                  owner_d [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0]           claimed_q, claimed_d;
   logic [SLOT_W-1:0]                  rr_ptr_q, rr_ptr_d;

   logic [NUM_CONSUMERS-1:0]           rd_ready_q, rd_ready_d;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q, rd_data_d;
   logic [NUM_CONSUMERS-1:0]           wr_ready_q, wr_ready_d;
   logic [NUM_CHANNELS-1:0]            mrd_valid_q, mrd_valid_d;
   logic [NUM_CHANNELS*ADDR_BITS-1:0]  mrd_addr_q, mrd_addr_d;
   logic [NUM_CHANNELS-1:0]            mwr_valid_q, mwr_valid_d;
   logic [NUM_CHANNELS*ADDR_BITS-1:0]  mwr_addr_q, mwr_addr_d;
   logic [NUM_CHANNELS*DATA_BITS-1:0]  mwr_data_q, mwr_data_d;

   logic [NUM_CONSUMERS-1:0]           granted;
   logic                               found;
   logic [SLOT_W-1:0]                  sel, cand, own;
   int unsigned                        idx;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      claimed_d   = claimed_q;
      rr_ptr_d    = rr_ptr_q;
      rd_ready_d  = rd_ready_q;
      rd_data_d   = rd_data_q;
      wr_ready_d  = wr_ready_q;
      mrd_valid_d = mrd_valid_q;
      mrd_addr_d  = mrd_addr_q;
      mwr_valid_d = mwr_valid_q;
      mwr_addr_d  = mwr_addr_q;
      mwr_data_d  = mwr_data_q;
      granted     = '0;
      found       = 1'b0;
      sel         = '0;
      cand        = '0;
      own         = '0;
      idx         = 0;

      // Channels resolve in ascending order; 'granted' keeps a slot from being
      // picked twice in the same cycle, 'claimed_q' across cycles.
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
         own = owner_q[ch];
         case (state_q[ch])
            S_IDLE: begin
               found = 1'b0;
               sel   = '0;
               for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
                  idx = 32'(rr_ptr_q) + k;
                  if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
                  cand = SLOT_W'(idx);
                  if (!found && !claimed_q[cand] && !granted[cand] &&
                      (req_read_valid[cand] || req_write_valid[cand])) begin
                     found = 1'b1;
                     sel   = cand;
                  end
               end
               if (found) begin
                  granted[sel]   = 1'b1;
                  claimed_d[sel] = 1'b1;
                  owner_d[ch]    = sel;
                  rr_ptr_d       = (32'(sel) == NUM_CONSUMERS - 1) ? '0 : sel + 1'b1;
                  if (req_write_valid[sel]) begin
                     mwr_valid_d[ch] = 1'b1;
                     mwr_addr_d[ch*ADDR_BITS +: ADDR_BITS] =
                        req_write_address[32'(sel)*ADDR_BITS +: ADDR_BITS];
                     mwr_data_d[ch*DATA_BITS +: DATA_BITS] =
                        req_write_data[32'(sel)*DATA_BITS +: DATA_BITS];
                     state_d[ch] = S_WRITE_WAIT;
                  end else begin
                     mrd_valid_d[ch] = 1'b1;
                     mrd_addr_d[ch*ADDR_BITS +: ADDR_BITS] =
                        req_read_address[32'(sel)*ADDR_BITS +: ADDR_BITS];
                     state_d[ch] = S_READ_WAIT;
                  end
               end
            end
            S_READ_WAIT: begin
               if (mem_read_ready[ch]) begin
                  mrd_valid_d[ch] = 1'b0;
                  if (req_read_valid[own]) begin
                     rd_data_d[32'(own)*DATA_BITS +: DATA_BITS] =
                        mem_read_data[ch*DATA_BITS +: DATA_BITS];
                     rd_ready_d[own] = 1'b1;
                     state_d[ch]     = S_READ_RELAY;
                  end else begin
                     claimed_d[own] = 1'b0;
                     state_d[ch]    = S_IDLE;
                  end
               end
            end
            S_WRITE_WAIT: begin
               if (mem_write_ready[ch]) begin
                  mwr_valid_d[ch] = 1'b0;
                  if (req_write_valid[own]) begin
                     wr_ready_d[own] = 1'b1;
                     state_d[ch]     = S_WRITE_RELAY;
                  end else begin
                     claimed_d[own] = 1'b0;
                     state_d[ch]    = S_IDLE;
                  end
               end
            end
            S_READ_RELAY: begin
               if (!req_read_valid[own]) begin
                  rd_ready_d[own] = 1'b0;
                  claimed_d[own]  = 1'b0;
                  state_d[ch]     = S_IDLE;
               end
            end
            S_WRITE_RELAY: begin
               if (!req_write_valid[own]) begin
                  wr_ready_d[own] = 1'b0;
                  claimed_d[own]  = 1'b0;
                  state_d[ch]     = S_IDLE;
               end
            end
            default: state_d[ch] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_q[ch] <= S_IDLE;
            owner_q[ch] <= '0;
         end
         claimed_q   <= '0;
         rr_ptr_q    <= '0;
         rd_ready_q  <= '0;
         rd_data_q   <= '0;
         wr_ready_q  <= '0;
         mrd_valid_q <= '0;
         mrd_addr_q  <= '0;
         mwr_valid_q <= '0;
         mwr_addr_q  <= '0;
         mwr_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         claimed_q   <= claimed_d;
         rr_ptr_q    <= rr_ptr_d;
         rd_ready_q  <= rd_ready_d;
         rd_data_q   <= rd_data_d;
         wr_ready_q  <= wr_ready_d;
         mrd_valid_q <= mrd_valid_d;
         mrd_addr_q  <= mrd_addr_d;
         mwr_valid_q <= mwr_valid_d;
         mwr_addr_q  <= mwr_addr_d;
         mwr_data_q  <= mwr_data_d;
      end
   end

   assign req_read_ready    = rd_ready_q;
   assign req_read_data     = rd_data_q;
   assign req_write_ready   = wr_ready_q;
   assign mem_read_valid    = mrd_valid_q;
   assign mem_read_address  = mrd_addr_q;
   assign mem_write_valid   = mwr_valid_q;
   assign mem_write_address = mwr_addr_q;
   assign mem_write_data    = mwr_data_q;

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Bench for dcache_mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level memory/consumer model.
module tb_dcache_mem_arbiter;

   localparam int A   = 8;
   localparam int D   = 8;
   localparam int NC  = 8;
   localparam int NCH = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [NC-1:0]   req_read_valid = '0;
   logic [NC*A-1:0] req_read_address = '0;
   logic [NC-1:0]   req_read_ready;
   logic [NC*D-1:0] req_read_data;
   logic [NC-1:0]   req_write_valid = '0;
   logic [NC*A-1:0] req_write_address = '0;
   logic [NC*D-1:0] req_write_data = '0;
   logic [NC-1:0]   req_write_ready;
   logic [NCH-1:0]   mem_read_valid;
   logic [NCH*A-1:0] mem_read_address;
   logic [NCH-1:0]   mem_read_ready = '0;
   logic [NCH*D-1:0] mem_read_data = '0;
   logic [NCH-1:0]   mem_write_valid;
   logic [NCH*A-1:0] mem_write_address;
   logic [NCH*D-1:0] mem_write_data;
   logic [NCH-1:0]   mem_write_ready = '0;

   int checks = 0;
   int errors = 0;

   logic [7:0]  rdata_tab [256];
   logic [15:0] wlog [$];
   int unsigned lat_fixed = 1;
   bit          lat_rand = 1'b0;
   int unsigned rcnt [NCH];
   int unsigned wcnt [NCH];
   bit          rbusy [NCH];
   bit          wbusy [NCH];

   dcache_mem_arbiter #(
      .ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)
   ) dut (
      .clk(clk), .reset(reset),
      .req_read_valid(req_read_valid), .req_read_address(req_read_address),
      .req_read_ready(req_read_ready), .req_read_data(req_read_data),
      .req_write_valid(req_write_valid), .req_write_address(req_write_address),
      .req_write_data(req_write_data), .req_write_ready(req_write_ready),
      .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
      .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
      .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
   );

   always #5 clk = ~clk;

   // Memory model: after seeing a channel's valid, waits its latency and pulses ready once.
   always @(posedge clk) begin
      #1;
      for (int c = 0; c < NCH; c++) begin
         if (!reset) begin
            rbusy[c] = 1'b0; wbusy[c] = 1'b0;
            mem_read_ready[c] = 1'b0; mem_write_ready[c] = 1'b0;
         end else begin
            if (mem_read_ready[c]) begin
               mem_read_ready[c] = 1'b0; rbusy[c] = 1'b0;
            end else if (rbusy[c]) begin
               if (rcnt[c] <= 1) begin
                  mem_read_data[c*D +: D] = rdata_tab[mem_read_address[c*A +: A]];
                  mem_read_ready[c] = 1'b1;
               end else rcnt[c]--;
            end else if (mem_read_valid[c]) begin
               rbusy[c] = 1'b1;
               rcnt[c]  = lat_rand ? $urandom_range(4, 1) : lat_fixed;
            end
            if (mem_write_ready[c]) begin
               mem_write_ready[c] = 1'b0; wbusy[c] = 1'b0;
            end else if (wbusy[c]) begin
               if (wcnt[c] <= 1) begin
                  wlog.push_back({mem_write_address[c*A +: A], mem_write_data[c*D +: D]});
                  mem_write_ready[c] = 1'b1;
               end else wcnt[c]--;
            end else if (mem_write_valid[c]) begin
               wbusy[c] = 1'b1;
               wcnt[c]  = lat_rand ? $urandom_range(4, 1) : lat_fixed;
            end
         end
      end
   end

   function automatic logic [7:0] mra(int c); return mem_read_address[c*A +: A]; endfunction
   function automatic logic [7:0] mwa(int c); return mem_write_address[c*A +: A]; endfunction
   function automatic logic [7:0] mwd(int c); return mem_write_data[c*D +: D]; endfunction
   function automatic logic [7:0] rdd(int s); return req_read_data[s*D +: D]; endfunction

   task automatic step(); @(negedge clk); endtask

   task automatic clear_reqs();
      req_read_valid = '0; req_write_valid = '0;
   endtask

   task automatic set_read(int s, logic [7:0] a);
      req_read_address[s*A +: A] = a; req_read_valid[s] = 1'b1;
   endtask

   task automatic set_write(int s, logic [7:0] a, logic [7:0] d);
      req_write_address[s*A +: A] = a; req_write_data[s*D +: D] = d; req_write_valid[s] = 1'b1;
   endtask

   task automatic pulse_reset();
      @(negedge clk); reset = 1'b0; clear_reqs();
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_reset();
      step();
      checks++;
      if ({mem_read_valid, mem_write_valid, req_read_ready, req_write_ready} !== '0) begin
         errors++; $display("FAIL reset_valids got %h want 0",
            {mem_read_valid, mem_write_valid, req_read_ready, req_write_ready});
      end
      checks++;
      if ({mem_read_address, mem_write_address, mem_write_data, req_read_data} !== '0) begin
         errors++; $display("FAIL reset_buses got %h want 0",
            {mem_read_address, mem_write_address, mem_write_data, req_read_data});
      end
      reset = 1'b1;
      step();
      checks++;
      if (mem_read_valid !== '0 || mem_write_valid !== '0) begin
         errors++; $display("FAIL idle_no_request got rd=%b wr=%b want 0", mem_read_valid, mem_write_valid);
      end
   endtask

   task automatic test_single_read();
      lat_fixed = 1;
      set_read(3, 8'h42);
      step();
      checks++;
      if (mem_read_valid !== 4'b0001 || mra(0) !== 8'h42) begin
         errors++; $display("FAIL single_issue got valid=%b addr=%h want 0001/42", mem_read_valid, mra(0));
      end
      step();
      checks++;
      if (req_read_ready !== '0) begin
         errors++; $display("FAIL single_early_ready got %b want 0", req_read_ready);
      end
      step();
      checks++;
      if (req_read_ready !== 8'b0000_1000 || rdd(3) !== 8'hA5 || mem_read_valid !== '0) begin
         errors++; $display("FAIL single_ready got rdy=%b data=%h mvalid=%b want 00001000/a5/0",
            req_read_ready, rdd(3), mem_read_valid);
      end
      req_read_valid[3] = 1'b0;
      step();
      checks++;
      if (req_read_ready !== '0) begin
         errors++; $display("FAIL single_ready_drop got %b want 0", req_read_ready);
      end
   endtask

   task automatic test_write_priority();
      lat_fixed = 1;
      wlog.delete();
      set_write(1, 8'h10, 8'h77);
      set_read(1, 8'h20);
      step();
      checks++;
      if (mem_write_valid !== 4'b0001 || mwa(0) !== 8'h10 || mwd(0) !== 8'h77 || mem_read_valid !== '0) begin
         errors++; $display("FAIL wp_issue got wv=%b a=%h d=%h rv=%b want 0001/10/77/0",
            mem_write_valid, mwa(0), mwd(0), mem_read_valid);
      end
      step(); step();
      checks++;
      if (req_write_ready !== 8'b0000_0010 || req_read_ready !== '0 || mem_write_valid !== '0) begin
         errors++; $display("FAIL wp_write_ready got wr=%b rr=%b mwv=%b want 00000010/0/0",
            req_write_ready, req_read_ready, mem_write_valid);
      end
      checks++;
      if (wlog.size() != 1 || wlog[0] !== 16'h1077) begin
         errors++; $display("FAIL wp_mem_write got n=%0d want one write of 1077", wlog.size());
      end
      req_write_valid[1] = 1'b0;
      step();
      checks++;
      if (req_write_ready !== '0 || mem_read_valid !== '0) begin
         errors++; $display("FAIL wp_relay_end got wr=%b rv=%b want 0/0", req_write_ready, mem_read_valid);
      end
      step();
      checks++;
      if (mem_read_valid !== 4'b0001 || mra(0) !== 8'h20) begin
         errors++; $display("FAIL wp_read_issue got rv=%b a=%h want 0001/20", mem_read_valid, mra(0));
      end
      step(); step();
      checks++;
      if (req_read_ready !== 8'b0000_0010 || rdd(1) !== rdata_tab[8'h20]) begin
         errors++; $display("FAIL wp_read_ready got rdy=%b d=%h want 00000010/%h",
            req_read_ready, rdd(1), rdata_tab[8'h20]);
      end
      req_read_valid[1] = 1'b0;
      step();
   endtask

   task automatic test_oversubscription();
      logic [7:0]    iss [NCH][4];
      int            iss_n [NCH];
      bit            pend [NC];
      logic [NCH-1:0] prev;
      int            served;
      pulse_reset();
      lat_fixed = 1;
      for (int s = 0; s < NC; s++) begin set_read(s, 8'(8'h80 + s)); pend[s] = 1'b1; end
      for (int c = 0; c < NCH; c++) iss_n[c] = 0;
      prev = '0; served = 0;
      step();
      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (mem_read_valid[c] !== 1'b1 || mra(c) !== 8'(8'h80 + c)) begin
            errors++; $display("FAIL os_first_round ch%0d got v=%b a=%h want 1/%h",
               c, mem_read_valid[c], mra(c), 8'(8'h80 + c));
         end
      end
      for (int cyc = 0; cyc < 40 && !(served == NC && mem_read_valid == '0); cyc++) begin
         for (int c = 0; c < NCH; c++)
            if (mem_read_valid[c] && !prev[c] && iss_n[c] < 4) begin iss[c][iss_n[c]] = mra(c); iss_n[c]++; end
         prev = mem_read_valid;
         for (int s = 0; s < NC; s++) begin
            if (req_read_ready[s]) begin
               checks++;
               if (!pend[s]) begin
                  errors++; $display("FAIL os_spurious slot%0d got ready=1 want 0", s);
               end else if (rdd(s) !== rdata_tab[8'h80 + s]) begin
                  errors++; $display("FAIL os_data slot%0d got %h want %h", s, rdd(s), rdata_tab[8'h80 + s]);
               end
               if (pend[s]) begin pend[s] = 1'b0; served++; req_read_valid[s] = 1'b0; end
            end
         end
         step();
      end
      checks++;
      if (served != NC) begin
         errors++; $display("FAIL os_all_served got %0d want %0d", served, NC);
      end
      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (iss_n[c] != 2 || iss[c][0] !== 8'(8'h80 + c) || iss[c][1] !== 8'(8'h84 + c)) begin
            errors++; $display("FAIL os_grant_order ch%0d got n=%0d want %h then %h",
               c, iss_n[c], 8'(8'h80 + c), 8'(8'h84 + c));
         end
      end
   endtask

   task automatic test_abandon();
      int ch;
      bit got;
      lat_fixed = 3;
      ch = -1;
      set_read(5, 8'h55);
      step();
      for (int c = 0; c < NCH; c++) if (mem_read_valid[c] && mra(c) == 8'h55) ch = c;
      checks++;
      if (ch < 0) begin
         errors++; $display("FAIL ab_issue got rv=%b want a channel reading 55", mem_read_valid);
      end
      req_read_valid[5] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (req_read_ready !== '0) begin
            errors++; $display("FAIL ab_no_ready got %b want 0", req_read_ready);
         end
      end
      checks++;
      if (mem_read_valid !== '0) begin
         errors++; $display("FAIL ab_channel_idle got rv=%b want 0", mem_read_valid);
      end
      lat_fixed = 1;
      set_read(5, 8'h56);
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         step();
         if (req_read_ready[5]) got = 1'b1;
      end
      checks++;
      if (!got || rdd(5) !== rdata_tab[8'h56]) begin
         errors++; $display("FAIL ab_reserve got ready=%b data=%h want 1/%h", got, rdd(5), rdata_tab[8'h56]);
      end
      req_read_valid[5] = 1'b0;
      step();
   endtask

   task automatic test_async_reset();
      lat_fixed = 4;
      set_read(2, 8'h33);
      step();
      checks++;
      if (mem_read_valid === '0) begin
         errors++; $display("FAIL ar_issue got rv=%b want nonzero", mem_read_valid);
      end
      #3;
      reset = 1'b0;
      #1;
      checks++;
      if ({mem_read_valid, mem_write_valid, req_read_ready, req_write_ready} !== '0) begin
         errors++; $display("FAIL ar_valids got %h want 0",
            {mem_read_valid, mem_write_valid, req_read_ready, req_write_ready});
      end
      checks++;
      if ({mem_read_address, mem_write_address, mem_write_data} !== '0 || req_read_data !== '0) begin
         errors++; $display("FAIL ar_buses got ma=%h rd=%h want 0", mem_read_address, req_read_data);
      end
      clear_reqs();
      step(); step();
      reset = 1'b1;
      lat_fixed = 1;
      set_read(6, 8'h66);
      set_read(1, 8'h11);
      step();
      checks++;
      if (mem_read_valid !== 4'b0011 || mra(0) !== 8'h11 || mra(1) !== 8'h66) begin
         errors++; $display("FAIL ar_regrant got rv=%b a0=%h a1=%h want 0011/11/66",
            mem_read_valid, mra(0), mra(1));
      end
      step(); step();
      checks++;
      if (req_read_ready !== 8'b0100_0010 || rdd(1) !== rdata_tab[8'h11] || rdd(6) !== rdata_tab[8'h66]) begin
         errors++; $display("FAIL ar_complete got rdy=%b d1=%h d6=%h want 01000010/%h/%h",
            req_read_ready, rdd(1), rdd(6), rdata_tab[8'h11], rdata_tab[8'h66]);
      end
      clear_reqs();
      step();
   endtask

   task automatic test_random_traffic();
      bit         pend [NC];
      bit         is_wr [NC];
      logic [7:0] ra [NC];
      logic [7:0] wd [NC];
      int         idle [NC];
      int         age [NC];
      int         done_n;
      bit         hit;
      pulse_reset();
      wlog.delete();
      lat_rand = 1'b1;
      done_n = 0;
      for (int s = 0; s < NC; s++) begin pend[s] = 1'b0; idle[s] = $urandom_range(3, 0); end
      for (int cyc = 0; cyc < 620; cyc++) begin
         step();
         for (int s = 0; s < NC; s++) begin
            if (pend[s]) begin
               age[s]++;
               checks++;
               if (is_wr[s] ? req_read_ready[s] : req_write_ready[s]) begin
                  errors++; $display("FAIL rnd_wrong_ready slot%0d got ready on other kind want 0", s);
               end
               if (is_wr[s] && req_write_ready[s]) begin
                  hit = 1'b0;
                  for (int i = 0; i < wlog.size(); i++)
                     if (!hit && wlog[i] === {ra[s], wd[s]}) begin hit = 1'b1; wlog.delete(i); end
                  checks++;
                  if (!hit) begin
                     errors++; $display("FAIL rnd_write slot%0d got no mem write want %h/%h", s, ra[s], wd[s]);
                  end
                  pend[s] = 1'b0; req_write_valid[s] = 1'b0; done_n++;
               end else if (!is_wr[s] && req_read_ready[s]) begin
                  checks++;
                  if (rdd(s) !== rdata_tab[ra[s]]) begin
                     errors++; $display("FAIL rnd_read slot%0d addr %h got %h want %h", s, ra[s], rdd(s), rdata_tab[ra[s]]);
                  end
                  pend[s] = 1'b0; req_read_valid[s] = 1'b0; done_n++;
               end else if (age[s] > 40) begin
                  checks++; errors++;
                  $display("FAIL rnd_timeout slot%0d got no ready after %0d cycles want served", s, age[s]);
                  pend[s] = 1'b0; req_read_valid[s] = 1'b0; req_write_valid[s] = 1'b0;
               end
               if (!pend[s]) idle[s] = $urandom_range(3, 0);
            end else begin
               checks++;
               if (req_read_ready[s] !== 1'b0 || req_write_ready[s] !== 1'b0) begin
                  errors++; $display("FAIL rnd_spurious slot%0d got r=%b w=%b want 0/0",
                     s, req_read_ready[s], req_write_ready[s]);
               end
               if (idle[s] > 0) idle[s]--;
               else if (cyc < 560) begin
                  is_wr[s] = 1'($urandom_range(1, 0));
                  ra[s] = 8'($urandom); wd[s] = 8'($urandom);
                  age[s] = 0; pend[s] = 1'b1;
                  if (is_wr[s]) set_write(s, ra[s], wd[s]); else set_read(s, ra[s]);
               end
            end
         end
      end
      checks++;
      if (done_n < 100) begin
         errors++; $display("FAIL rnd_progress got %0d completions want >=100", done_n);
      end
      checks++;
      if (wlog.size() != 0) begin
         errors++; $display("FAIL rnd_extra_writes got %0d unmatched want 0", wlog.size());
      end
      lat_rand = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) rdata_tab[i] = 8'((i * 37 + 11) & 8'hFF);
      rdata_tab[8'h42] = 8'hA5;
      test_reset();
      test_single_read();
      test_write_priority();
      test_oversubscription();
      test_abandon();
      test_async_reset();
      test_random_traffic();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
